user_rv_sync_filt: RTL
======================

USER_RV_SYNC_FILT -- requirements
Module: user_rv_sync_filt

Interface
REQ-001 Parameter WIDTH, default 1, number of independent channels; legal range 1..64.
REQ-002 Parameter STAGES, default 2, synchroniser flop depth per channel; legal range 2..4.
REQ-003 Parameter DEFAULT, WIDTH bits, default 0, reset value of every channel's chain, q and filter state.
REQ-004 Parameter FILT_CYCLES, default 0, consecutive stable cycles required before q updates; 0 = filter bypass; legal range 0..255.
REQ-005 clk  input  1  destination-domain clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 d  input  WIDTH  asynchronous input bits, one per channel.
REQ-008 q  output  WIDTH  synchronised, filtered level.
REQ-009 rise  output  WIDTH  one-cycle pulse in the first cycle q[i] reads 1 after being 0.
REQ-010 fall  output  WIDTH  one-cycle pulse in the first cycle q[i] reads 0 after being 1.
REQ-011 glitch  output  WIDTH  one-cycle pulse when a pending change of channel i is rejected.

Function
REQ-012 Each channel SHALL pass d[i] through STAGES flops; s[i] denotes the last stage.
REQ-013 FILT_CYCLES=0: q SHALL equal s; latency from d sampled at edge 1 to q = STAGES edges; glitch SHALL be constant 0.
REQ-014 FILT_CYCLES=F>0: per-channel counter cnt, width clog2(F+1), SHALL be kept.
REQ-015 On each edge with s[i]!=q[i] and cnt[i]<F-1: cnt[i] increments, q[i] holds.
REQ-016 On each edge with s[i]!=q[i] and cnt[i]==F-1: q[i]<=s[i], cnt[i]<=0; total latency STAGES+F edges.
REQ-017 On each edge with s[i]==q[i]: cnt[i]<=0; if cnt[i]!=0 beforehand, glitch[i] SHALL pulse for exactly the next cycle.
REQ-018 F=1: glitch SHALL never assert (counter is always 0).
REQ-019 rise/fall SHALL be registered alongside the q update, asserting in the same cycle q first shows the new value, never both set for one channel.
REQ-020 Channels SHALL be fully independent; simultaneous events on different channels SHALL each be handled per REQ-015..019.
REQ-021 cnt SHALL never exceed F-1; no wrap-around is possible.

Reset
REQ-022 While rst_n=0, all synchroniser stages and q SHALL equal DEFAULT, cnt=0, rise=fall=glitch=0, regardless of clk.
REQ-023 Reset asserted mid-count SHALL discard the pending change; after release q stays DEFAULT until d differs for STAGES+F edges.
REQ-024 First edge after reset release SHALL produce no rise/fall/glitch pulse.

Structure
REQ-025 Limits STAGES_MIN=2, STAGES_MAX=4, FILT_MAX=255 SHALL live in shared package user_cells_pkg; elaboration SHALL fail on out-of-range parameters.
REQ-026 One sub-module, user_rv_sync_filt_chan (single-bit chain, counter, pulse logic), SHALL be instantiated WIDTH times by generate.
REQ-027 No combinational path from d to any output; all outputs registered.

Verification
REQ-028 WIDTH=1, STAGES=2, F=0, DEFAULT=0: d 0->1 before edge 1 -> q=1 and rise=1 after edge 2, rise=0 after edge 3.
REQ-029 STAGES=3, F=4: d held 1 from edge 1 -> q=1 and rise pulse after edge 7, not before.
REQ-030 STAGES=2, F=4: d=1 for 2 cycles then 0 -> q stays 0, glitch pulses once, cnt returns 0.
REQ-031 WIDTH=4, DEFAULT=4'b1010, F=2: reset release -> q=4'b1010, no pulses; d=4'b0101 -> q=4'b0101 after 4 edges, rise=4'b0101, fall=4'b1010 same cycle.
REQ-032 F=8: rst_n asserted at cnt=5 -> q=DEFAULT immediately; d unchanged after release -> q updates after STAGES+8 edges.
REQ-033 Random per-channel d with pulses shorter than F: q never changes, glitch count equals rejected-pulse count in scoreboard.

Source files
------------

// File: rtl/user_cells_pkg.sv
// Shared limits and small types for the user_* cell library.
// Parameter range checks and the synchroniser/filter channel use these definitions.
package user_cells_pkg;

  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int FILT_MAX   = 255;

  // Event pulses produced by one filtered synchroniser channel.
  typedef struct packed {
    logic rise;
    logic fall;
    logic glitch;
  } chan_evt_t;

  // Filter counter width; a minimal one-bit counter when the filter is bypassed.
  function automatic int cnt_width(input int filt_cycles);
    return (filt_cycles < 1) ? 1 : $clog2(filt_cycles + 1);
  endfunction

endpackage

// File: rtl/user_rv_sync_filt_chan.sv
// One channel: STAGES-deep synchroniser, optional stability filter, and registered
// rise/fall/glitch pulses.
module user_rv_sync_filt_chan
  import user_cells_pkg::*;
#(
  parameter int   STAGES      = 2,
  parameter int   FILT_CYCLES = 0,
  parameter logic DEFAULT     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic glitch
);

  // The first STAGES-1 flops are common; the last stage depends on the filter mode.
  logic [STAGES-2:0] r_sync;
  logic              w_pre;
  logic              r_q;
  chan_evt_t         r_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {(STAGES-1){DEFAULT}};
    end else begin
      r_sync[0] <= d;
      for (int k = 1; k < STAGES-1; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_pre = r_sync[STAGES-2];

  if (FILT_CYCLES == 0) begin : g_bypass
    // r_q is itself the final synchroniser stage, so q follows d after STAGES edges.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q   <= DEFAULT;
        r_evt <= '0;
      end else begin
        r_q          <= w_pre;
        r_evt.rise   <= w_pre & ~r_q;
        r_evt.fall   <= ~w_pre & r_q;
        r_evt.glitch <= 1'b0;
      end
    end
  end else begin : g_filter
    localparam int            CW       = cnt_width(FILT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

    logic          r_s;
    logic [CW-1:0] r_cnt;

    // A change must persist for FILT_CYCLES consecutive edges at the last stage to reach q.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s   <= DEFAULT;
        r_q   <= DEFAULT;
        r_cnt <= '0;
        r_evt <= '0;
      end else begin
        r_s   <= w_pre;
        r_evt <= '0;
        if (r_s != r_q) begin
          if (r_cnt == CNT_LAST) begin
            r_q        <= r_s;
            r_cnt      <= '0;
            r_evt.rise <= r_s;
            r_evt.fall <= ~r_s;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end else begin
          r_cnt        <= '0;
          r_evt.glitch <= (r_cnt != '0);
        end
      end
    end
  end

  assign q      = r_q;
  assign rise   = r_evt.rise;
  assign fall   = r_evt.fall;
  assign glitch = r_evt.glitch;

endmodule

// File: rtl/user_rv_sync_filt.sv
// Multi-channel level synchroniser with optional per-channel glitch filter.
// Each bit is handled by an independent user_rv_sync_filt_chan; all outputs are registered.
module user_rv_sync_filt
  import user_cells_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] DEFAULT     = '0,
  parameter int               FILT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] glitch
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("user_rv_sync_filt: WIDTH %0d out of range", WIDTH);
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("user_rv_sync_filt: STAGES %0d out of range", STAGES);
  end
  if (FILT_CYCLES < 0 || FILT_CYCLES > FILT_MAX) begin : g_bad_filt
    $error("user_rv_sync_filt: FILT_CYCLES %0d out of range", FILT_CYCLES);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    user_rv_sync_filt_chan #(
      .STAGES      (STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .DEFAULT     (DEFAULT[i])
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .d      (d[i]),
      .q      (q[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .glitch (glitch[i])
    );
  end

endmodule
